// File: rtl/button_debounce_sched.sv
// Shared-timer debounce scheduler: one prescaler and scan FSM debounce N buttons and queue press/release events.
// Optional build macro AUTOREPEAT_EN adds hold-time auto-repeat press events.
module button_debounce_sched #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned STABLE_CNT = 8,
    parameter int unsigned REP_DELAY  = 64,
    parameter int unsigned REP_RATE   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [N_BTN-1:0]                         btn_in,
    output logic [N_BTN-1:0]                         btn_state,
    output logic                                     evt_valid,
    input  logic                                     evt_ready,
    output logic [$clog2((N_BTN > 1) ? N_BTN : 2)-1:0] evt_id,
    output logic                                     evt_press,
    output logic                                     evt_ovf,
    input  logic                                     ovf_clr,
    output logic                                     busy
);

    localparam int unsigned ID_W  = $clog2((N_BTN > 1) ? N_BTN : 2);
    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam int unsigned PS_W  = $clog2((TICK_DIV > 1) ? TICK_DIV : 2);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            st, st_nx;
    logic [ID_W-1:0]   idx;
    logic [N_BTN-1:0]  sync1, sync2;
    logic [PS_W-1:0]   ps_cnt;
    logic              tick;
    logic [CNT_W-1:0]  cnt [N_BTN];
    logic [CNT_W-1:0]  cnt_inc;
    logic              visit, differ, flip, rep;
    logic              post_v, post_p, drop;
    logic [N_BTN-1:0]  slot_v, slot_p;
    logic [ID_W-1:0]   rr_ptr, sel_id;
    logic              sel_found, load, drain;
    logic [ID_W:0]     jw;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            ps_cnt <= '0;
        end else begin
            sync1  <= btn_in;
            sync2  <= sync1;
            ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            idx <= '0;
        end else begin
            st <= st_nx;
            if (st == SCAN)
                idx <= (idx == ID_W'(N_BTN - 1)) ? '0 : idx + ID_W'(1);
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (tick) st_nx = SCAN;
            SCAN:    if (idx == ID_W'(N_BTN - 1)) st_nx = DONE;
            DONE:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    assign busy    = (st != IDLE);
    assign visit   = (st == SCAN);
    assign differ  = (sync2[idx] != btn_state[idx]);
    assign cnt_inc = cnt[idx] + CNT_W'(1);
    assign flip    = visit && differ && (cnt_inc == CNT_W'(STABLE_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_state <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else if (visit) begin
            if (!differ || flip) cnt[idx] <= '0;
            else                 cnt[idx] <= cnt_inc;
            if (flip) btn_state[idx] <= ~btn_state[idx];
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REP_DELAY + REP_RATE + 1);
    logic [HOLD_W-1:0] hold [N_BTN];
    logic [HOLD_W-1:0] hold_inc;

    assign hold_inc = hold[idx] + HOLD_W'(1);
    assign rep = visit && btn_state[idx] && !flip &&
                 ((hold_inc == HOLD_W'(REP_DELAY)) || (hold_inc == HOLD_W'(REP_DELAY + REP_RATE)));

    // After the first repeat the counter loops between REP_DELAY and REP_DELAY+REP_RATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) hold[i] <= '0;
        end else if (visit) begin
            if (!btn_state[idx] || flip)                   hold[idx] <= '0;
            else if (hold_inc == HOLD_W'(REP_DELAY + REP_RATE)) hold[idx] <= HOLD_W'(REP_DELAY);
            else                                           hold[idx] <= hold_inc;
        end
    end
`else
    assign rep = 1'b0;
`endif

    assign post_v = flip || rep;
    assign post_p = flip ? ~btn_state[idx] : 1'b1;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        jw        = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            jw = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (jw >= (ID_W + 1)'(N_BTN)) jw = jw - (ID_W + 1)'(N_BTN);
            if (!sel_found && slot_v[jw[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = jw[ID_W-1:0];
            end
        end
    end

    assign load  = !evt_valid || evt_ready;
    assign drain = load && sel_found;
    // A slot draining this cycle can take a new post without overflow.
    assign drop  = post_v && slot_v[idx] && !(drain && (sel_id == idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v <= '0;
            slot_p <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (post_v && (idx == ID_W'(i)) && !drop) begin
                    slot_v[i] <= 1'b1;
                    slot_p[i] <= post_p;
                end else if (drain && (sel_id == ID_W'(i))) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_press <= 1'b0;
            rr_ptr    <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            if (load) begin
                evt_valid <= sel_found;
                if (sel_found) begin
                    evt_id    <= sel_id;
                    evt_press <= slot_p[sel_id];
                    rr_ptr    <= (sel_id == ID_W'(N_BTN - 1)) ? '0 : sel_id + ID_W'(1);
                end
            end
            if (drop && !rep)  evt_ovf <= 1'b1;
            else if (ovf_clr)  evt_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_debounce_sched.sv
// Bench for button_debounce_sched: table of button patterns plus hand sequences, events checked by a scoreboard.
module tb_button_debounce_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned TD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = '0;
    logic [3:0] btn_state;
    logic       evt_valid, evt_ready = 1'b1;
    logic [1:0] evt_id;
    logic       evt_press, evt_ovf, busy;
    logic       ovf_clr = 1'b0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce_sched #(
        .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(3), .REP_DELAY(4), .REP_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_press(evt_press), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr), .busy(busy)
    );

    typedef struct { logic [1:0] id; logic press; } evt_t;
    typedef struct { logic [3:0] btn; int unsigned ticks; logic [3:0] st; } vec_t;
    typedef struct { int unsigned cyc; logic [1:0] id; logic press; } log_t;

    evt_t sb[$];
    log_t log_q[$];
    vec_t vecs[11];
    int   n_vec = 0;
    int   n_err = 0;
    bit   sb_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_changes(input logic [3:0] old_s, input logic [3:0] new_s);
        for (int i = 0; i < 4; i++)
            if (old_s[i] != new_s[i]) sb.push_back('{id: 2'(i), press: new_s[i]});
    endtask

    task automatic monitor();
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ready) begin
                if (sb_en) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL evt_unexpected: got id=%0d press=%0d expected none", evt_id, evt_press);
                    end else begin
                        e = sb.pop_front();
                        if (evt_id !== e.id || evt_press !== e.press) begin
                            n_err++;
                            $display("FAIL evt: got id=%0d press=%0d expected id=%0d press=%0d",
                                     evt_id, evt_press, e.id, e.press);
                        end
                    end
                end else begin
                    log_q.push_back('{cyc: cyc, id: evt_id, press: evt_press});
                end
            end
        end
    endtask

    initial begin
        int unsigned k;
        logic [3:0]  prev;

        vecs[0]  = '{btn: 4'b0100, ticks: 5,  st: 4'b0100};
        vecs[1]  = '{btn: 4'b0000, ticks: 5,  st: 4'b0000};
        vecs[2]  = '{btn: 4'b0010, ticks: 2,  st: 4'b0000};
        vecs[3]  = '{btn: 4'b0000, ticks: 4,  st: 4'b0000};
        vecs[4]  = '{btn: 4'b1010, ticks: 5,  st: 4'b1010};
        vecs[5]  = '{btn: 4'b0011, ticks: 5,  st: 4'b0011};
        vecs[6]  = '{btn: 4'b0000, ticks: 5,  st: 4'b0000};
        vecs[7]  = '{btn: 4'b1111, ticks: 5,  st: 4'b1111};
        vecs[8]  = '{btn: 4'b0000, ticks: 5,  st: 4'b0000};
        vecs[9]  = '{btn: 4'b0001, ticks: 12, st: 4'b0001};
        vecs[10] = '{btn: 4'b0000, ticks: 5,  st: 4'b0000};

        fork monitor(); join_none

        step(3);
        check("rst_state", 32'(btn_state), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id",    32'(evt_id),    0);
        check("rst_press", 32'(evt_press), 0);
        check("rst_ovf",   32'(evt_ovf),   0);
        check("rst_busy",  32'(busy),      0);

        rst = 1'b0;
        k = 0;
        while (!busy && k < 100) begin step(1); k++; end
        check("first_tick", k, 16);
        k = 0;
        while (busy && k < 100) begin step(1); k++; end
        check("busy_len", k, 5);

`ifndef AUTOREPEAT_EN
        prev = '0;
        for (int v = 0; v < 11; v++) begin
            btn_in = vecs[v].btn;
            push_changes(prev, vecs[v].st);
            step(vecs[v].ticks * TD);
            check("vec_state", 32'(btn_state), 32'(vecs[v].st));
            check("vec_drain", sb.size(), 0);
            prev = vecs[v].st;
        end

        // two simultaneous presses with the consumer stalled
        evt_ready = 1'b0;
        btn_in = 4'b1001;
        push_changes(4'b0000, 4'b1001);
        k = 0;
        while (!evt_valid && k < 8 * TD) begin step(1); k++; end
        check("t3_valid_seen", 32'(evt_valid), 1);
        for (int c = 0; c < 20; c++) begin
            check("t3_hold_valid", 32'(evt_valid), 1);
            check("t3_hold_id",    32'(evt_id),    0);
            check("t3_hold_press", 32'(evt_press), 1);
            step(1);
        end
        evt_ready = 1'b1;
        step(1);
        check("t3_next_valid", 32'(evt_valid), 1);
        check("t3_next_id",    32'(evt_id),    3);
        step(1);
        check("t3_empty", 32'(evt_valid), 0);
        btn_in = 4'b0000;
        push_changes(4'b1001, 4'b0000);
        step(5 * TD);
        check("t3_state", 32'(btn_state), 0);
        check("t3_drain", sb.size(), 0);

        // press, release, press with consumer stalled: third event overflows
        evt_ready = 1'b0;
        btn_in = 4'b0010;
        push_changes(4'b0000, 4'b0010);
        step(5 * TD);
        check("t4_valid", 32'(evt_valid), 1);
        check("t4_id",    32'(evt_id),    1);
        check("t4_press", 32'(evt_press), 1);
        btn_in = 4'b0000;
        push_changes(4'b0010, 4'b0000);
        step(5 * TD);
        check("t4_ovf_pre", 32'(evt_ovf), 0);
        btn_in = 4'b0010;
        step(5 * TD);
        check("t4_ovf_set", 32'(evt_ovf), 1);
        check("t4_state",   32'(btn_state), 2);
        check("t4_still_id",    32'(evt_id),    1);
        check("t4_still_press", 32'(evt_press), 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(evt_ovf), 0);
        evt_ready = 1'b1;
        step(4);
        check("t4_drain", sb.size(), 0);
        btn_in = 4'b0000;
        push_changes(4'b0010, 4'b0000);
        step(5 * TD);
        check("t4_rel_state", 32'(btn_state), 0);
        check("t4_rel_drain", sb.size(), 0);

        // reset while scanning with pending slots
        evt_ready = 1'b0;
        btn_in = 4'b1101;
        step(5 * TD);
        check("t5_valid", 32'(evt_valid), 1);
        check("t5_id",    32'(evt_id),    0);
        k = 0;
        while (!busy && k < 2 * TD) begin step(1); k++; end
        check("t5_busy", 32'(busy), 1);
        rst = 1'b1;
        btn_in = 4'b0000;
        sb.delete();
        step(1);
        check("t5_state", 32'(btn_state), 0);
        check("t5_evalid", 32'(evt_valid), 0);
        check("t5_id0",   32'(evt_id),    0);
        check("t5_press", 32'(evt_press), 0);
        check("t5_ovf",   32'(evt_ovf),   0);
        check("t5_idle",  32'(busy),      0);
        rst = 1'b0;
        evt_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 8 * TD; c++) begin
            if (evt_valid) k++;
            step(1);
        end
        check("t5_no_evt", k, 0);
        check("t5_state_after", 32'(btn_state), 0);
`else
        // held button with auto-repeat
        sb_en = 1'b0;
        evt_ready = 1'b1;
        btn_in = 4'b0001;
        k = 0;
        while (!btn_state[0] && k < 8 * TD) begin step(1); k++; end
        check("t6_pressed", 32'(btn_state[0]), 1);
        step(11 * TD);
        btn_in = 4'b0000;
        step(6 * TD);
        check("t6_released", 32'(btn_state), 0);
        check("t6_ovf", 32'(evt_ovf), 0);
        check("t6_count_ok", 32'(log_q.size() >= 6), 1);
        if (log_q.size() >= 6) begin
            for (int i = 0; i < 5; i++) begin
                check("t6_id",    32'(log_q[i].id),    0);
                check("t6_press", 32'(log_q[i].press), 1);
            end
            for (int i = 1; i < 5; i++)
                check("t6_gap", log_q[i].cyc - log_q[i-1].cyc, (i == 1) ? 4 * TD : 2 * TD);
            check("t6_last_release", 32'(log_q[log_q.size()-1].press), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
